// File: rtl/index_vector_assembler.sv
// Purpose : collects a frame of bit indices into a WIDTH-bit mask and emits it as one vector.
// Latency : the vector is valid the cycle after the last index is accepted; a new frame can start the cycle after the vector handshake.
// Backpr. : while the vector waits for vec_ready_i, idx_ready_o is low and the vector outputs hold.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   clear_i                  synchronous clear of the current frame and any pending vector
//   idx_valid_i/idx_ready_o  index handshake; idx_i is the bit to set, idx_last_i ends the frame
//   vec_valid_o/vec_ready_i  vector handshake
//   vec_o, vec_count_o       assembled mask and its number of set bits
//   dup_o, oor_o             frame had a repeated index / an index >= WIDTH
module index_vector_assembler #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             idx_valid_i,
  output logic             idx_ready_o,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             idx_last_i,
  output logic             vec_valid_o,
  input  logic             vec_ready_i,
  output logic [WIDTH-1:0] vec_o,
  output logic [CNT_W-1:0] vec_count_o,
  output logic             dup_o,
  output logic             oor_o
);

  if (WIDTH < 2) begin : g_width_chk
    $error("index_vector_assembler: WIDTH must be >= 2");
  end

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_OUTPUT  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_mask;
  logic [CNT_W-1:0] r_count;
  logic             r_dup;
  logic             r_oor;

  logic [WIDTH-1:0] w_onehot;
  logic             w_in_range;
  logic             w_hit;
  logic             w_idx_acc;
  logic             w_vec_acc;

  // Shifting a one past the top of the mask yields zero, so an all-zero
  // one-hot doubles as the out-of-range detector for non-power-of-two WIDTH.
  assign w_onehot   = {{(WIDTH-1){1'b0}}, 1'b1} << idx_i;
  assign w_in_range = |w_onehot;
  assign w_hit      = |(r_mask & w_onehot);

  assign w_idx_acc  = idx_valid_i & (r_state == S_COLLECT);
  assign w_vec_acc  = vec_ready_i & (r_state == S_OUTPUT);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; clear overrides both handshakes
  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = S_COLLECT;
    end else begin
      case (r_state)
        S_COLLECT: if (idx_valid_i && idx_last_i) w_state_nxt = S_OUTPUT;
        S_OUTPUT:  if (vec_ready_i)               w_state_nxt = S_COLLECT;
        default:   w_state_nxt = S_COLLECT;
      endcase
    end
  end

  // Handshake outputs decoded from state only
  always_comb begin
    idx_ready_o = (r_state == S_COLLECT);
    vec_valid_o = (r_state == S_OUTPUT);
  end

  // Accumulator: zeroed when the vector leaves or on clear, updated per accepted index
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mask  <= '0;
      r_count <= '0;
      r_dup   <= 1'b0;
      r_oor   <= 1'b0;
    end else if (clear_i || w_vec_acc) begin
      r_mask  <= '0;
      r_count <= '0;
      r_dup   <= 1'b0;
      r_oor   <= 1'b0;
    end else if (w_idx_acc) begin
      if (!w_in_range) begin
        r_oor <= 1'b1;
      end else if (w_hit) begin
        r_dup <= 1'b1;
      end else begin
        r_mask  <= r_mask | w_onehot;
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign vec_o       = r_mask;
  assign vec_count_o = r_count;
  assign dup_o       = r_dup;
  assign oor_o       = r_oor;

endmodule
